// File: rtl/gpio_map_pkg.sv
// Shared types, address/bit constants and entry validation for the GPIO pin-map controller.
package gpio_map_pkg;

    localparam int unsigned SEL_W = 6;

    localparam logic [5:0]       CTRL_ADDR = 6'd63;
    localparam logic [SEL_W-1:0] UNMAPPED  = '1;

    localparam int unsigned CTRL_COMMIT  = 0;
    localparam int unsigned CTRL_CLR_ERR = 1;

    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_PENDING = 1;
    localparam int unsigned STAT_ERR     = 2;
    localparam int unsigned STAT_OE      = 3;

    typedef enum logic [1:0] {
        StIdle,
        StDrain,
        StLoad,
        StSettle
    } state_e;

    // Valid selects are 0..io_width+1 (iobits plus the two LEDs) and the unmapped code.
    function automatic logic is_invalid(logic [SEL_W-1:0] v, int unsigned io_width);
        return (32'(v) > io_width + 1) && (v != UNMAPPED);
    endfunction

    function automatic logic [SEL_W-1:0] sanitise(logic [SEL_W-1:0] v, int unsigned io_width);
        return is_invalid(v, io_width) ? UNMAPPED : v;
    endfunction

endpackage

// File: rtl/gpio_map_guard_timer.sv
// Loadable down-counter with zero flag; times both guard intervals of a commit.
module gpio_map_guard_timer #(
    parameter int unsigned CntW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [CntW-1:0] load_val,
    output logic            zero
);

    logic [CntW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/gpio_map_ctrl.sv
// GPIO pin-map controller: Avalon-MM shadow table, active table and break-before-make commit.
module gpio_map_ctrl
    import gpio_map_pkg::*;
#(
    parameter int unsigned GPIOWidth   = 36,
    parameter int unsigned IOWidth     = 34,
    parameter int unsigned SelW        = SEL_W,
    parameter int unsigned GuardCycles = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [5:0]                address,
    input  logic                      write,
    input  logic [31:0]               writedata,
    input  logic                      read,
    output logic [31:0]               readdata,
    output logic                      waitrequest,
    output logic [GPIOWidth*SelW-1:0] map_sel,
    output logic                      map_oe,
    output logic                      busy
);

    localparam logic [5:0] NumEntries = 6'(GPIOWidth);
    localparam logic [7:0] GuardLoad  = 8'(GuardCycles - 1);

    logic [SelW-1:0] shadow [GPIOWidth];
    logic [SelW-1:0] active [GPIOWidth];

    state_e state;
    logic   pending;
    logic   err;
    logic   timer_load;
    logic   timer_zero;

    logic in_map;
    logic is_ctrl;
    logic map_wr;
    logic commit_req;
    logic clr_err;

    assign in_map      = address < NumEntries;
    assign is_ctrl     = address == CTRL_ADDR;
    assign waitrequest = busy & write & in_map;
    assign map_wr      = write & in_map & ~busy;
    assign commit_req  = write & is_ctrl & writedata[CTRL_COMMIT];
    assign clr_err     = write & is_ctrl & writedata[CTRL_CLR_ERR];

    // Shadow table, sticky error flag and registered read port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < GPIOWidth; i++) begin
                shadow[i] <= SelW'(i);
            end
            err      <= 1'b0;
            readdata <= '0;
        end else begin
            if (map_wr) begin
                shadow[address] <= writedata[SelW-1:0];
            end
            if (map_wr && is_invalid(writedata[SelW-1:0], IOWidth)) begin
                err <= 1'b1;
            end else if (clr_err) begin
                err <= 1'b0;
            end
            if (read) begin
                if (in_map) begin
                    readdata <= 32'(shadow[address]);
                end else if (is_ctrl) begin
                    readdata <= 32'({map_oe, err, pending, busy});
                end else begin
                    readdata <= '0;
                end
            end
        end
    end

    always_comb begin
        timer_load = 1'b0;
        unique case (state)
            StIdle:   timer_load = commit_req;
            StDrain:  timer_load = 1'b0;
            StLoad:   timer_load = 1'b1;
            StSettle: timer_load = timer_zero & (pending | commit_req);
        endcase
    end

    gpio_map_guard_timer #(
        .CntW(8)
    ) u_guard_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (GuardLoad),
        .zero     (timer_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= StIdle;
            busy    <= 1'b0;
            map_oe  <= 1'b0;
            pending <= 1'b0;
            for (int i = 0; i < GPIOWidth; i++) begin
                active[i] <= UNMAPPED;
            end
        end else begin
            unique case (state)
                StIdle: begin
                    if (commit_req) begin
                        state  <= StDrain;
                        busy   <= 1'b1;
                        map_oe <= 1'b0;
                    end
                end
                StDrain: begin
                    if (commit_req) pending <= 1'b1;
                    if (timer_zero) state <= StLoad;
                end
                StLoad: begin
                    if (commit_req) pending <= 1'b1;
                    for (int i = 0; i < GPIOWidth; i++) begin
                        active[i] <= sanitise(shadow[i], IOWidth);
                    end
                    state <= StSettle;
                end
                StSettle: begin
                    if (timer_zero) begin
                        // A queued request chains straight into another drain with pins still off.
                        if (pending || commit_req) begin
                            state   <= StDrain;
                            pending <= 1'b0;
                        end else begin
                            state  <= StIdle;
                            busy   <= 1'b0;
                            map_oe <= 1'b1;
                        end
                    end else if (commit_req) begin
                        pending <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        map_sel = '0;
        for (int i = 0; i < GPIOWidth; i++) begin
            map_sel[i*SelW +: SelW] = active[i];
        end
    end

endmodule

// File: tb/tb_gpio_map_ctrl.sv
// Directed self-checking bench for gpio_map_ctrl with default parameters (GuardCycles=16).
module tb_gpio_map_ctrl;

    logic          clk;
    logic          reset;
    logic [5:0]    address;
    logic          write;
    logic [31:0]   writedata;
    logic          read;
    logic [31:0]   readdata;
    logic          waitrequest;
    logic [215:0]  map_sel;
    logic          map_oe;
    logic          busy;

    int checks   = 0;
    int failures = 0;
    int n;
    logic [31:0] rd;

    gpio_map_ctrl u_dut (
        .clk         (clk),
        .reset       (reset),
        .address     (address),
        .write       (write),
        .writedata   (writedata),
        .read        (read),
        .readdata    (readdata),
        .waitrequest (waitrequest),
        .map_sel     (map_sel),
        .map_oe      (map_oe),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] sel_of(input int i);
        return map_sel[i*6 +: 6];
    endfunction

    // Returns #1 after the accepting edge.
    task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
        int w = 0;
        address = a; writedata = d; write = 1'b1;
        #1;
        while (waitrequest && w < 200) begin
            @(posedge clk); #1; w++;
        end
        if (w >= 200) check("write_timeout", 64'(w), 64'd0);
        @(posedge clk); #1;
        write = 1'b0;
    endtask

    task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
        address = a; read = 1'b1;
        @(posedge clk); #1;
        read = 1'b0;
        d = readdata;
    endtask

    // n already counts the accepting edge; keeps counting edges until map_oe rises.
    task automatic wait_oe(inout int cnt);
        while (!map_oe && cnt < 200) begin
            @(posedge clk); #1; cnt++;
        end
    endtask

    initial begin
        reset = 1'b1; address = '0; write = 1'b0; writedata = '0; read = 1'b0;
        #1;
        check("rst_map_oe", 64'(map_oe), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_readdata", 64'(readdata), 64'd0);
        check("rst_waitrequest", 64'(waitrequest), 64'd0);
        check("rst_sel_unmapped", 64'(map_sel === {216{1'b1}}), 64'd1);
        #21 reset = 1'b0;
        @(posedge clk); #1;

        bus_read(6'd5, rd);
        check("rd_shadow5", 64'(rd), 64'd5);
        bus_read(6'd63, rd);
        check("rd_status_rst", 64'(rd), 64'd0);
        bus_read(6'd40, rd);
        check("rd_unused", 64'(rd), 64'd0);

        // First commit: 34 edges from the accepting edge (inclusive) until map_oe is high.
        bus_write(6'd63, 32'h1);
        check("c1_busy_rise", 64'(busy), 64'd1);
        n = 1;
        wait_oe(n);
        check("c1_latency", 64'(n), 64'd34);
        check("c1_busy_fall", 64'(busy), 64'd0);
        check("c1_sel16", 64'(sel_of(16)), 64'd16);
        check("c1_sel35", 64'(sel_of(35)), 64'd35);

        // Map write during a commit is stalled until busy falls.
        bus_write(6'd63, 32'h1);
        address = 6'd0; writedata = 32'd16; write = 1'b1;
        #1;
        check("stall_wait_hi", 64'(waitrequest), 64'd1);
        n = 0;
        while (waitrequest && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check("stall_busy_at_release", 64'(busy), 64'd0);
        @(posedge clk); #1;
        write = 1'b0;
        check("stall_sel0_old", 64'(sel_of(0)), 64'd0);
        bus_read(6'd0, rd);
        check("stall_shadow0", 64'(rd), 64'd16);
        bus_write(6'd63, 32'h1);
        check("c2_oe_low", 64'(map_oe), 64'd0);
        n = 1;
        wait_oe(n);
        check("c2_latency", 64'(n), 64'd34);
        check("c2_sel0", 64'(sel_of(0)), 64'd16);
        check("c2_sel16_fanout", 64'(sel_of(16)), 64'd16);

        // Out-of-range select: stored as written, flagged, driven as unmapped.
        bus_write(6'd3, 32'd40);
        bus_read(6'd63, rd);
        check("err_set", 64'(rd), 64'hC);
        bus_read(6'd3, rd);
        check("err_shadow3", 64'(rd), 64'd40);
        bus_write(6'd63, 32'h1);
        n = 1;
        wait_oe(n);
        check("err_sel3", 64'(sel_of(3)), 64'd63);
        check("err_sel4", 64'(sel_of(4)), 64'd4);
        bus_read(6'd63, rd);
        check("err_status_after", 64'(rd), 64'hC);
        bus_write(6'd63, 32'h2);
        bus_read(6'd63, rd);
        check("err_cleared", 64'(rd), 64'h8);

        // Three extra requests in DRAIN collapse into one chained sequence: 34 + 33 edges.
        bus_write(6'd63, 32'h1);
        n = 1;
        bus_write(6'd63, 32'h1); n++;
        bus_write(6'd63, 32'h1); n++;
        bus_write(6'd63, 32'h1); n++;
        bus_read(6'd63, rd); n++;
        check("pend_status", 64'(rd), 64'h3);
        wait_oe(n);
        check("pend_latency", 64'(n), 64'd67);
        bus_read(6'd63, rd);
        check("pend_done_status", 64'(rd), 64'h8);

        // Asynchronous reset in the middle of SETTLE.
        bus_write(6'd63, 32'h1);
        repeat (23) @(posedge clk);
        #3;
        check("mid_busy", 64'(busy), 64'd1);
        check("mid_sel0_loaded", 64'(sel_of(0)), 64'd16);
        reset = 1'b1;
        #1;
        check("arst_map_oe", 64'(map_oe), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_sel_unmapped", 64'(map_sel === {216{1'b1}}), 64'd1);
        #10 reset = 1'b0;
        @(posedge clk); #1;
        bus_read(6'd0, rd);
        check("arst_shadow0", 64'(rd), 64'd0);
        bus_read(6'd3, rd);
        check("arst_shadow3", 64'(rd), 64'd3);
        bus_read(6'd63, rd);
        check("arst_status", 64'(rd), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
